// File: rtl/multi_lane_striper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_lane_pkg
// Desc     : Shared symbol constants and PCIe Gen1 LFSR scramble helper
// Revision : 1.0 - initial release
// ============================================================================
package multi_lane_pkg;

    localparam logic [7:0]  SYM_COM     = 8'hBC;
    localparam logic [7:0]  SYM_SKP     = 8'h1C;
    localparam logic [15:0] LFSR_SEED   = 16'hFFFF;
    localparam logic [15:0] LFSR_POLY   = 16'h0039;
    localparam int          LFSR_MAX_DW = 16;

    typedef logic [LFSR_MAX_DW-1:0] sym_t;

    // Returns {data_out, lfsr_next}; only the low 'width' bits are processed.
    function automatic logic [LFSR_MAX_DW+15:0] lfsr_scramble(
        input sym_t        data,
        input logic        k,
        input logic [15:0] lfsr,
        input int          width
    );
        sym_t        d_out;
        logic [15:0] l;
        d_out = data;
        l     = lfsr;
        for (int b = 0; b < LFSR_MAX_DW; b++) begin
            if (b < width) begin
                if (!k) begin
                    d_out[b] = data[b] ^ l[15];
                end
                l = {l[14:0], 1'b0} ^ (l[15] ? LFSR_POLY : 16'h0000);
            end
        end
        if (k && (data == sym_t'(SYM_COM))) begin
            l = LFSR_SEED;
        end else if (k && (data == sym_t'(SYM_SKP))) begin
            l = lfsr;
        end
        return {d_out, l};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : lane_scrambler
// Desc     : One lane of Gen1 scrambling: combinational scramble, registered LFSR
// Revision : 1.0 - initial release
// ============================================================================
module lane_scrambler
    import multi_lane_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  active,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  k,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  k_out
);

    logic [15:0]             r_lfsr;
    sym_t                    w_data_ext;
    logic [LFSR_MAX_DW+15:0] w_result;

    always_comb begin
        w_data_ext                 = '0;
        w_data_ext[DATA_WIDTH-1:0] = data;
    end

    assign w_result = lfsr_scramble(w_data_ext, k, r_lfsr, DATA_WIDTH);
    assign data_out = w_result[16 +: DATA_WIDTH];
    assign k_out    = k;

    if (DATA_WIDTH < LFSR_MAX_DW) begin : g_pad
        logic [LFSR_MAX_DW-DATA_WIDTH-1:0] w_unused_hi;
        assign w_unused_hi = w_result[16+DATA_WIDTH +: LFSR_MAX_DW-DATA_WIDTH];
    end

    // An idle lane sits at the seed so it starts clean when the link widens.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr <= LFSR_SEED;
        end else if (!active) begin
            r_lfsr <= LFSR_SEED;
        end else if (en) begin
            r_lfsr <= w_result[15:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_lane_striper.sv
`default_nettype none
// ============================================================================
// Module   : multi_lane_striper
// Desc     : Round-robin symbol striper across 1..NUM_LANES scrambled lanes
// Revision : 1.0 - initial release
// ============================================================================
module multi_lane_striper
    import multi_lane_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [$clog2(NUM_LANES):0]      active_lanes_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            data_k_i,
    input  logic                            data_valid_i,
    output logic                            data_ready_o,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_o,
    output logic [NUM_LANES-1:0]            lane_k_o,
    output logic [NUM_LANES-1:0]            lane_enable_o,
    output logic                            lane_valid_o,
    input  logic                            lane_ready_i
);

    localparam int c_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int c_WID_W = $clog2(NUM_LANES) + 1;

    logic [c_IDX_W-1:0]                          r_idx;
    logic [c_WID_W-1:0]                          r_width;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]        r_stage_data;
    logic [NUM_LANES-1:0]                        r_stage_k;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]        r_out_data;
    logic [NUM_LANES-1:0]                        r_out_k;
    logic                                        r_valid;

    logic [c_WID_W-1:0]                          w_width_sel;
    logic [NUM_LANES-1:0]                        w_lane_active;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]        w_scr_data;
    logic [NUM_LANES-1:0]                        w_scr_k;
    logic                                        w_last;
    logic                                        w_ready;
    logic                                        w_accept;
    logic                                        w_complete;
    logic                                        w_group_idle;

    // Non power-of-two or oversized widths fall back to x1.
    always_comb begin
        w_width_sel = c_WID_W'(1);
        if ((active_lanes_i != '0) &&
            ((active_lanes_i & (active_lanes_i - 1'b1)) == '0) &&
            (active_lanes_i <= c_WID_W'(NUM_LANES))) begin
            w_width_sel = active_lanes_i;
        end
    end

    assign w_last       = (c_WID_W'(r_idx) == (r_width - 1'b1));
    assign w_ready      = !w_last || !r_valid || lane_ready_i;
    assign w_accept     = data_valid_i && w_ready;
    assign w_complete   = w_accept && w_last;
    assign w_group_idle = w_complete || ((r_idx == '0) && !w_accept);

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        assign w_lane_active[n] = (c_WID_W'(n) < r_width);

        lane_scrambler #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_scr (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .active   (w_lane_active[n]),
            .en       (w_accept && (r_idx == c_IDX_W'(n))),
            .data     (data_i),
            .k        (data_k_i),
            .data_out (w_scr_data[n]),
            .k_out    (w_scr_k[n])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx        <= '0;
            r_width      <= c_WID_W'(1);
            r_stage_data <= '0;
            r_stage_k    <= '0;
            r_out_data   <= '0;
            r_out_k      <= '0;
            r_valid      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_stage_data[r_idx] <= w_scr_data[r_idx];
                r_stage_k[r_idx]    <= w_scr_k[r_idx];
                r_idx               <= w_last ? '0 : r_idx + 1'b1;
            end
            // The completing symbol bypasses staging so the group lands in one edge.
            if (w_complete) begin
                for (int n = 0; n < NUM_LANES; n++) begin
                    if (!w_lane_active[n]) begin
                        r_out_data[n] <= '0;
                        r_out_k[n]    <= 1'b0;
                    end else if (r_idx == c_IDX_W'(n)) begin
                        r_out_data[n] <= w_scr_data[n];
                        r_out_k[n]    <= w_scr_k[n];
                    end else begin
                        r_out_data[n] <= r_stage_data[n];
                        r_out_k[n]    <= r_stage_k[n];
                    end
                end
                r_valid <= 1'b1;
            end else if (r_valid && lane_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_group_idle) begin
                r_width <= w_width_sel;
            end
        end
    end

    assign data_ready_o  = w_ready;
    assign lane_data_o   = r_out_data;
    assign lane_k_o      = r_out_k;
    assign lane_valid_o  = r_valid;
    assign lane_enable_o = w_lane_active;

endmodule
`default_nettype wire

// File: doc/multi_lane_striper.md
# multi_lane_striper

Parametrised transmit-side byte striper for the PCIe physical layer. It accepts a single symbol stream with a K-flag from the link layer and distributes consecutive symbols round-robin across 1..NUM_LANES active lanes. Each symbol is scrambled by a per-lane PCIe Gen1 LFSR, and the block presents one aligned symbol-time (one symbol per active lane) to the per-lane 8b10b encoders. It replaces the fixed broadcast-to-all-lanes scrambling front end with link-width selection, K-symbol bypass, COM/SKP LFSR handling and ready/valid backpressure on both sides.

## Interface
Parameters:
- NUM_LANES, 4: physical lane count; power of two, 1..16.
- DATA_WIDTH, 8: symbol width in bits; the LFSR advances DATA_WIDTH shifts per scrambled symbol.

Ports:
- clk_i, in, 1: single clock. Reset is asynchronous and active-high.
- rst_i, in, 1: asynchronous, active-high reset.
- active_lanes_i, in, $clog2(NUM_LANES)+1: link width. Legal values are 1, 2, 4 … NUM_LANES; any other value is treated as 1.
- data_i, in, DATA_WIDTH: input symbol.
- data_k_i, in, 1: data_i is a K (control) symbol.
- data_valid_i, in, 1: the input symbol is valid.
- data_ready_o, out, 1: the block accepts the symbol this cycle.
- lane_data_o, out, NUM_LANES*DATA_WIDTH: lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- lane_k_o, out, NUM_LANES: per-lane K flag.
- lane_enable_o, out, NUM_LANES: mask of active lanes for the current width.
- lane_valid_o, out, 1: one symbol-time is valid on all active lanes.
- lane_ready_i, in, 1: the downstream encoders consume the symbol-time.

## Operation
- A symbol is accepted when data_valid_i && data_ready_o.
- Lane index idx counts from 0 to W-1, where W is the registered width width_q. Accepted symbol number k of a group goes to lane k. idx returns to 0 after the symbol for lane W-1.
- width_q loads from active_lanes_i only while idx==0 and no partial group is staged. A width change never splits a group.
- Scrambling, per lane, using the Galois LFSR with polynomial x^16+x^5+x^4+x^3+1 (mask 16'h0039) and seed 16'hFFFF:
  - For each bit b, LSB first: out[b] = in[b] ^ lfsr[15], then lfsr = {lfsr[14:0],1'b0} ^ (lfsr[15] ? 16'h0039 : 0).
  - Data symbols (k=0) are scrambled and advance the LFSR.
  - K symbols pass unscrambled.
  - COM (K28.5, 8'hBC) reloads that lane's LFSR to 16'hFFFF.
  - SKP (K28.0, 8'h1C) leaves the LFSR unchanged.
  - All other K symbols advance the LFSR without altering the data.
- Accepted symbols are written into a staging register at their lane slot.
- When the last symbol of a group is accepted, the whole group (including that final symbol) transfers into the output register and lane_valid_o is set. lane_valid_o clears on lane_valid_o && lane_ready_i unless a new group completes in the same cycle.
- data_ready_o = (idx != W-1) || !lane_valid_o || lane_ready_i. Only the group-completing symbol is backpressured.
- Inactive lanes always output data 0 and k 0. Their LFSRs hold 16'hFFFF and do not advance.
- lane_enable_o bit n = (n < W).

## Timing
- Reset values: lane_data_o=0, lane_k_o=0, lane_valid_o=0, lane_enable_o=1 (lane 0 only), width_q=1, idx=0, all LFSRs 16'hFFFF. data_ready_o is 1 while in reset.
- Latency: the completing symbol accepted in cycle N gives lane_valid_o=1 in cycle N+1.
- Throughput: one symbol per clock sustained, so a full symbol-time every W cycles with lane_ready_i held at 1. For W=1 this is one symbol-time per cycle.
- Simultaneous drain and fill: if the output register is drained and the next group completes in the same cycle, lane_valid_o stays 1 with the new data and there is no bubble.
- Backpressure: while lane_valid_o=1 and lane_ready_i=0, lane_data_o, lane_k_o and lane_valid_o are stable.
- Reset asserted mid-group discards the partial group and any pending output. State returns to reset values asynchronously.

## Structure
- Package multi_lane_pkg holds:
  - SYM_COM=8'hBC, SYM_SKP=8'h1C
  - LFSR_SEED=16'hFFFF, LFSR_POLY=16'h0039
  - function lfsr_scramble(data, k, lfsr) returning {data_out, lfsr_next}
- Sub-module lane_scrambler, instantiated NUM_LANES times in a generate loop. It is combinational scramble logic around a registered LFSR, with inputs en (this lane's symbol accepted), data, k, and outputs data_out, k_out.
- The top level contains the idx counter, width_q, staging register, output register and handshake logic.

## Test plan
- x1, send K28.5 then 16 data 8'h00 -> lane 0 outputs BC(k), then FF 17 C0 14 B2 E7 02 82 … (the Gen1 scrambler sequence), one symbol-time per cycle.
- x4, send COM on all 4 lanes then 8 data symbols 8'h00 -> each lane outputs BC(k), then FF, then 17. lane_enable_o=4'hF, and lane_valid_o pulses every 4 cycles.
- x2, insert SKP between data symbols on lane 0 -> lane 0 output continues FF, 1C(k), 17. The LFSR does not advance on SKP.
- Hold lane_ready_i=0 after the first group completes -> data_ready_o drops when the next group's last symbol is presented, outputs stay stable, and no symbols are lost after release.
- Change active_lanes_i from 4 to 2 mid-group -> the current x4 group completes unchanged, and the next group uses lanes 0-1 with lanes 2-3 outputting zero.
- Assert rst_i after 3 of 4 symbols -> lane_valid_o=0, no partial output; the next COM plus data reproduces the FF sequence.
